// File: rtl/pixl_pkg.sv
// Shared types and constants for the pixl 3x3 window engine.
// FSM and serial sub-state enums, sizing localparams, saturation helper.
package pixl_pkg;

  localparam int unsigned CLK_DIV    = 163;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned N_TAPS     = 9;
  localparam int unsigned ACC_W      = 20;

  typedef enum logic [1:0] {
    LOAD_K,
    LOAD_P,
    MAC,
    SEND
  } eng_st_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } ser_st_t;

  function automatic logic [7:0] sat8(
    input logic [ACC_W-1:0] a
  );
    return (a > ACC_W'(255)) ? 8'hFF : a[7:0];
  endfunction

endpackage

// File: rtl/pixl_serial.sv
// Baud tick generator plus 8N1 receiver and transmitter.
// Ports: clk, rst_n, rx/tx line, rx_data/rx_done, tx_data/tx_start/tx_busy.
module pixl_serial
  import pixl_pkg::*;
#(
  parameter int unsigned DIV = CLK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] OS_MID   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic [DW-1:0] div_q, div_d;
  logic          tick;

  logic [1:0] rx_sync_q;
  logic       rx_prev_q;
  logic       rx_s;

  ser_st_t    rs_q, rs_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic [2:0] rbit_q, rbit_d;
  logic [7:0] rsh_q, rsh_d;
  logic       rdone_q, rdone_d;

  ser_st_t    ts_q, ts_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] tbit_q, tbit_d;
  logic [7:0] tsh_q, tsh_d;
  logic       txo_q, txo_d;

  assign tick    = (div_q == DW'(DIV - 1));
  assign rx_s    = rx_sync_q[1];
  assign rx_data = rsh_q;
  assign rx_done = rdone_q;
  assign tx      = txo_q;
  assign tx_busy = (ts_q != IDLE);

  always_comb begin
    div_d = tick ? '0 : div_q + DW'(1);
  end

  always_comb begin
    rs_d    = rs_q;
    rcnt_d  = rcnt_q;
    rbit_d  = rbit_q;
    rsh_d   = rsh_q;
    rdone_d = 1'b0;
    unique case (rs_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rs_d   = START;
          rcnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (rcnt_q == OS_MID) begin
            // a glitch shorter than half a bit is not a start
            rcnt_d = '0;
            rbit_d = '0;
            rs_d   = rx_s ? IDLE : DATA;
          end else begin
            rcnt_d = rcnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (rcnt_q == OS_LAST) begin
            rcnt_d = '0;
            rsh_d  = {rx_s, rsh_q[7:1]};
            if (rbit_q == BIT_LAST) begin
              rs_d = STOP;
            end else begin
              rbit_d = rbit_q + 3'd1;
            end
          end else begin
            rcnt_d = rcnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (rcnt_q == OS_LAST) begin
            rs_d    = IDLE;
            rdone_d = rx_s;
          end else begin
            rcnt_d = rcnt_q + 4'd1;
          end
        end
      end
      default: rs_d = IDLE;
    endcase
  end

  always_comb begin
    ts_d   = ts_q;
    tcnt_d = tcnt_q;
    tbit_d = tbit_q;
    tsh_d  = tsh_q;
    txo_d  = txo_q;
    unique case (ts_q)
      IDLE: begin
        txo_d = 1'b1;
        if (tx_start) begin
          ts_d   = START;
          tcnt_d = '0;
          tsh_d  = tx_data;
          txo_d  = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (tcnt_q == OS_LAST) begin
            ts_d   = DATA;
            tcnt_d = '0;
            tbit_d = '0;
            txo_d  = tsh_q[0];
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tcnt_q == OS_LAST) begin
            tcnt_d = '0;
            if (tbit_q == BIT_LAST) begin
              ts_d  = STOP;
              txo_d = 1'b1;
            end else begin
              tbit_d = tbit_q + 3'd1;
              tsh_d  = {1'b0, tsh_q[7:1]};
              txo_d  = tsh_q[1];
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tcnt_q == OS_LAST) begin
            ts_d = IDLE;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      default: ts_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
      rs_q      <= IDLE;
      rcnt_q    <= '0;
      rbit_q    <= '0;
      rsh_q     <= '0;
      rdone_q   <= 1'b0;
      ts_q      <= IDLE;
      tcnt_q    <= '0;
      tbit_q    <= '0;
      tsh_q     <= '0;
      txo_q     <= 1'b1;
    end else begin
      div_q     <= div_d;
      rx_sync_q <= {rx_sync_q[0], rx};
      rx_prev_q <= rx_s;
      rs_q      <= rs_d;
      rcnt_q    <= rcnt_d;
      rbit_q    <= rbit_d;
      rsh_q     <= rsh_d;
      rdone_q   <= rdone_d;
      ts_q      <= ts_d;
      tcnt_q    <= tcnt_d;
      tbit_q    <= tbit_d;
      tsh_q     <= tsh_d;
      txo_q     <= txo_d;
    end
  end

endmodule

// File: rtl/pixl_engine.sv
// UART-attached 3x3 window engine: kernel, then pixel windows, saturated dot product out.
// Ports: clk, reset (async active-low), rx (serial in), tx (serial out).
module pixl_engine
  import pixl_pkg::*;
#(
  parameter int unsigned BAUD_DIV = CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic tx
);

  localparam logic [3:0] LAST = 4'(N_TAPS - 1);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  eng_st_t          st_q, st_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       kern_q [N_TAPS];
  logic [7:0]       kern_d [N_TAPS];
  logic [7:0]       pix_q  [N_TAPS];
  logic [7:0]       pix_d  [N_TAPS];
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic             in_v;
  logic [7:0]       in_b;
  logic [15:0]      prod;

  // assert immediately, release two clocks after reset rises
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  pixl_serial #(
    .DIV(BAUD_DIV)
  ) u_serial (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .tx       (tx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  assign prod    = {8'd0, kern_q[idx_q]} * {8'd0, pix_q[idx_q]};
  assign tx_data = sat8(acc_q);

  // byte source: holding register drains first once back in a load state
  always_comb begin
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    in_v     = 1'b0;
    in_b     = rx_data;
    if (st_q == LOAD_K || st_q == LOAD_P) begin
      if (hold_v_q) begin
        in_v     = 1'b1;
        in_b     = hold_q;
        hold_v_d = rx_done;
        hold_d   = rx_done ? rx_data : hold_q;
      end else begin
        in_v = rx_done;
      end
    end else if (rx_done) begin
      hold_v_d = 1'b1;
      hold_d   = rx_data;
    end
  end

  always_comb begin
    st_d     = st_q;
    idx_d    = idx_q;
    kern_d   = kern_q;
    pix_d    = pix_q;
    acc_d    = acc_q;
    tx_start = 1'b0;
    unique case (st_q)
      LOAD_K: begin
        if (in_v) begin
          kern_d[idx_q] = in_b;
          if (idx_q == LAST) begin
            idx_d = '0;
            st_d  = LOAD_P;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      LOAD_P: begin
        if (in_v) begin
          pix_d[idx_q] = in_b;
          if (idx_q == LAST) begin
            idx_d = '0;
            acc_d = '0;
            st_d  = MAC;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      MAC: begin
        acc_d = acc_q + {{(ACC_W - 16){1'b0}}, prod};
        if (idx_q == LAST) begin
          idx_d = '0;
          st_d  = SEND;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          st_d     = LOAD_P;
        end
      end
      default: st_d = LOAD_K;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= LOAD_K;
      idx_q    <= '0;
      acc_q    <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      for (int i = 0; i < int'(N_TAPS); i++) begin
        kern_q[i] <= '0;
        pix_q[i]  <= '0;
      end
    end else begin
      st_q     <= st_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      kern_q   <= kern_d;
      pix_q    <= pix_d;
    end
  end

endmodule

// File: tb/tb_pixl_engine.sv
// Directed bench for pixl_engine with a fast baud divider.
// Drives 8N1 frames on rx and decodes tx frames into a queue.
module tb_pixl_engine;

  localparam int D  = 2;
  localparam int BP = 16 * D;

  typedef struct {
    logic [7:0] d;
    logic       stp;
    logic       st0;
    int         w;
  } frm_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic tx;

  int passed = 0;
  int total = 0;
  int failed = 0;

  frm_t q[$];
  frm_t mf;
  bit   rose;

  pixl_engine #(
    .BAUD_DIV(D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #20;
    forever begin
      @(negedge tx);
      rose  = 1'b0;
      mf.w  = 0;
      mf.d  = '0;
      for (int c = 1; c <= BP * 9 + BP / 2; c++) begin
        @(negedge clk);
        if (!rose && tx === 1'b1) begin
          rose = 1'b1;
          mf.w = c - 1;
        end
        if (c == BP / 2) mf.st0 = tx;
        for (int j = 0; j < 8; j++) begin
          if (c == BP / 2 + BP * (j + 1)) mf.d[j] = tx;
        end
        if (c == BP * 9 + BP / 2) mf.stp = tx;
      end
      q.push_back(mf);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stp);
    @(negedge clk);
    rx = 1'b0;
    repeat (BP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BP) @(negedge clk);
    end
    rx = stp;
    repeat (BP) @(negedge clk);
    rx = 1'b1;
    repeat (BP) @(negedge clk);
  endtask

  task automatic send_rep(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_byte(b, 1'b1);
  endtask

  task automatic send_ramp(input logic [7:0] b, input int n);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < n; i++) begin
      send_byte(v, 1'b1);
      v = v + 8'd1;
    end
  endtask

  task automatic exp_frame(input string tag, input logic [7:0] val);
    frm_t f;
    for (int i = 0; i < 14 * BP && q.size() == 0; i++) @(negedge clk);
    if (q.size() == 0) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    f = q.pop_front();
    chk({tag, "_data"}, int'(f.d), int'(val));
    chk({tag, "_start"}, int'(f.st0), 0);
    chk({tag, "_stop"}, int'(f.stp), 1);
    if (val[0]) begin
      chk({tag, "_startw"}, int'(f.w >= 15 * D + 1 && f.w <= 16 * D), 1);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    chk("rst_tx_hi", int'(tx), 1);
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #3;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (25) @(negedge clk);
      chk("rst_hold_tx", int'(tx), 1);
    end
    chk("rst_hold_nofrm", q.size(), 0);
    reset = 1'b1;
    repeat (20 * BP) @(negedge clk);
    chk("rst_rel_tx", int'(tx), 1);
    chk("rst_rel_nofrm", q.size(), 0);

    send_ramp(8'd0, 9);
    send_ramp(8'd1, 9);
    exp_frame("basic", 8'hF0);

    send_rep(8'd1, 9);
    exp_frame("retain", 8'h24);

    send_byte(8'h50, 1'b0);
    repeat (2 * BP) @(negedge clk);
    chk("ferr_nofrm", q.size(), 0);
    send_ramp(8'd1, 9);
    exp_frame("ferr", 8'hF0);

    send_rep(8'h10, 5);
    do_reset(10);
    send_rep(8'd1, 9);
    send_ramp(8'd1, 9);
    exp_frame("midrst", 8'h2D);

    send_rep(8'd28, 8);
    send_byte(8'd31, 1'b1);
    exp_frame("sat255", 8'hFF);

    send_rep(8'd28, 8);
    send_byte(8'd32, 1'b1);
    exp_frame("sat256", 8'hFF);

    send_rep(8'd28, 8);
    send_byte(8'd30, 1'b1);
    exp_frame("sat254", 8'hFE);

    do_reset(10);
    send_rep(8'hFF, 9);
    send_rep(8'hFF, 9);
    exp_frame("satmax", 8'hFF);

    repeat (12 * BP) @(negedge clk);
    chk("end_nofrm", q.size(), 0);
    chk("end_tx", int'(tx), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pixl_engine.md
Name: pixl_engine

Overview:
- UART-attached 3x3 pixel-window processor: receives 9 kernel coefficients, then 9 pixel bytes, over a serial line.
- Computes their unsigned dot product and returns the saturated 8-bit result as one byte on the serial transmit line.
- Sits between a host UART (8N1, ~9600 baud at 25 MHz) and the rest of the image pipeline.
- The kernel is retained, so subsequent 9-byte pixel windows each produce one result byte.

Parameters:
- CLK_DIV, 163, system clocks per oversample tick.
- OVERSAMPLE, 16, ticks per bit.
- DATA_BITS, 8, data bits per UART frame (no parity, 1 stop bit).
- N_TAPS, 9, coefficients and pixels per window.
- ACC_W, 20, accumulator width (must be at least 16 + ceil(log2 N_TAPS)).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial input, idle high, asynchronous to clk.
- tx  output  1  serial output, idle high.

Behaviour:
- Reset (reset=0):
  - tx=1; FSM=LOAD_K; tap counter=0; kernel, pixel and accumulator registers cleared.
  - Baud divider cleared; receiver and transmitter idle.
- Release from reset is synchronised internally: 2-flop deassertion.
- Mid-frame reset aborts any rx/tx frame immediately; tx forced high.
- rx path:
  - 2-flop synchroniser.
  - Start detected on sampled falling edge, then confirmed low at tick 7.
  - Data sampled every 16 ticks thereafter, LSB first.
  - Stop bit sampled 16 ticks after the last data bit.
  - Stop=0 is a framing error: byte discarded, receiver returns to idle.
  - A good byte raises a one-clock rx_done strobe.
- Baud tick: one-clock pulse every CLK_DIV clocks, free-running, shared by rx and tx.
- FSM states:
  - LOAD_K: each rx_done stores the byte in kernel[idx], idx++. At idx=8, store, clear idx, go to LOAD_P.
  - LOAD_P: same, into pixel[idx]. On the 9th byte go to MAC.
  - MAC: serial multiply-accumulate, one tap per clock over 9 clocks, acc += kernel[i]*pixel[i].
    - Operands are unsigned 8x8 giving a 16-bit product; acc is ACC_W bits.
    - Then result = (acc > 255) ? 255 : acc[7:0]. Go to SEND.
  - SEND:
    - If the transmitter is idle, load result, pulse tx_start, return to LOAD_P.
    - Otherwise hold in SEND until the transmitter is idle.
- Bytes arriving in MAC/SEND are not lost:
  - One-byte holding register, consumed on return to LOAD_P.
  - A second byte arriving while the holding register is full overwrites it.
- tx frame: start bit (0), 8 data bits LSB first, 1 stop bit (1), each lasting 16 ticks. tx_busy is high from tx_start until the end of the stop bit.
- Latency: the tx start bit begins within 12 clocks of rx_done for the 9th pixel byte.
- Counters wrap only via explicit clear; idx never exceeds 8.
- Kernel is reloaded only after reset.

Decomposition:
- Package pixl_pkg holds:
  - localparams CLK_DIV, OVERSAMPLE, N_TAPS, ACC_W.
  - FSM state enum (LOAD_K, LOAD_P, MAC, SEND).
  - rx/tx sub-state enum (IDLE, START, DATA, STOP).
- One sub-module, pixl_serial: baud tick generator plus 8N1 receiver and transmitter.
  - Interface: rx_data/rx_done, tx_data/tx_start/tx_busy.
- The FSM, buffers and MAC live in pixl_engine.

Test Plan:
- Reset behaviour: hold reset=0 for 100 clks → tx stays 1, no tx activity; release → tx remains 1 with no byte emitted.
- Basic window:
  - Send kernel 0..8, then pixels 1..9 → exactly one tx byte, 0xF0 (240).
  - Framing is correct: each bit lasts 163*16 clks.
- Saturation: kernel all 0xFF, pixels all 0xFF → tx byte 0xFF.
- Retained kernel: after the basic window, send pixels 9 x 0x01 → tx byte 0x24 (36); no kernel reload needed.
- Framing error: send one frame with stop bit 0 during LOAD_P → byte ignored; tap count unchanged (the next 9 good bytes produce the result).
- Reset mid-operation: assert reset after 5 kernel bytes, then send a full 18-byte sequence → result computed from the new bytes only.
